// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush arbiter for the 5-stage MIPS pipeline: picks between memory wait,
// taken branch, load-use and jump, and tracks stall statistics and memory timeout.
module pipeline_hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int STAT_W   = 16,
    parameter int WAIT_W   = 8,
    parameter int MAX_WAIT = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ifid_flush,
    output logic              idex_hold,
    output logic              idex_bubble,
    output logic              exmem_hold,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] stall_cycles,
    output logic              mem_timeout
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic [STAT_W-1:0]   stall_q, stall_d;
    logic                load_use;
    logic                ifid_hold_c;

    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_d     = state_q;
        pc_hold     = 1'b0;
        ifid_hold_c = 1'b0;
        ifid_flush  = 1'b0;
        idex_hold   = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        case (state_q)
            RUN, LOAD_STALL: begin
                if (mem_busy) begin
                    pc_hold     = 1'b1;
                    ifid_hold_c = 1'b1;
                    idex_hold   = 1'b1;
                    exmem_hold  = 1'b1;
                    state_d     = MEM_WAIT;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = RUN;
                end else if (state_q == RUN && load_use) begin
                    pc_hold     = 1'b1;
                    ifid_hold_c = 1'b1;
                    idex_bubble = 1'b1;
                    state_d     = LOAD_STALL;
                end else if (state_q == RUN && jump) begin
                    ifid_flush  = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d     = RUN;
                end
            end
            MEM_WAIT: begin
                // Whole front of the pipe freezes; a pending branch/hazard re-presents after.
                if (mem_busy) begin
                    pc_hold     = 1'b1;
                    ifid_hold_c = 1'b1;
                    idex_hold   = 1'b1;
                    exmem_hold  = 1'b1;
                end else begin
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            pc_hold     = 1'b0;
            ifid_hold_c = 1'b0;
            ifid_flush  = 1'b0;
            idex_hold   = 1'b0;
            idex_bubble = 1'b0;
            exmem_hold  = 1'b0;
        end
    end

    // Flush dominates hold on IF/ID.
    assign ifid_hold = ifid_hold_c & ~ifid_flush;

    always_comb begin
        if (!mem_busy)              wait_d = '0;
        else if (wait_q >= WAIT_MAX) wait_d = WAIT_MAX;
        else                         wait_d = wait_q + 1'b1;
        timeout_d = timeout_q | (wait_d == WAIT_MAX);
        if (stat_clr)                       stall_d = '0;
        else if (pc_hold && stall_q != '1)  stall_d = stall_q + 1'b1;
        else                                stall_d = stall_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    assign state        = state_q;
    assign stall_cycles = stall_q;
    assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for single-cycle decisions,
// hand sequences for stalls, memory wait, timeout, saturation and async reset.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, jump, mem_busy, stat_clr;
    logic       pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold;
    logic [1:0] state;
    logic [1:0] stall_cycles;
    logic       mem_timeout;
    logic [5:0] ctl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(5), .STAT_W(2), .WAIT_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken), .jump(jump),
        .mem_busy(mem_busy), .stat_clr(stat_clr), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
        .ifid_flush(ifid_flush), .idex_hold(idex_hold), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .state(state), .stall_cycles(stall_cycles),
        .mem_timeout(mem_timeout)
    );

    assign ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold};

    typedef struct packed {
        logic       mb, br, rd;
        logic [4:0] xrt, rs, rt;
        logic       urt, jmp;
        logic [5:0] exp_ctl;
        logic [1:0] exp_nst;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle;
        mem_busy = 0; branch_taken = 0; ex_mem_read = 0; ex_rt = 0;
        id_rs = 0; id_rt = 0; id_uses_rt = 0; jump = 0; stat_clr = 0;
    endtask

    task automatic load_use8;
        ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8;
    endtask

    initial begin
        // ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold}
        vecs[0] = '{0,0,0, 5'd0, 5'd0, 5'd0, 0,0, 6'b000000, 2'd0};
        vecs[1] = '{0,0,1, 5'd8, 5'd8, 5'd3, 0,0, 6'b110010, 2'd1};
        vecs[2] = '{0,0,1, 5'd0, 5'd0, 5'd0, 1,0, 6'b000000, 2'd0};
        vecs[3] = '{0,0,1, 5'd9, 5'd1, 5'd9, 0,0, 6'b000000, 2'd0};
        vecs[4] = '{0,0,1, 5'd9, 5'd1, 5'd9, 1,0, 6'b110010, 2'd1};
        vecs[5] = '{0,1,1, 5'd8, 5'd8, 5'd0, 0,0, 6'b001010, 2'd0};
        vecs[6] = '{0,0,0, 5'd0, 5'd0, 5'd0, 0,1, 6'b001000, 2'd0};
        vecs[7] = '{1,1,1, 5'd8, 5'd8, 5'd0, 0,1, 6'b110101, 2'd2};
        vecs[8] = '{0,0,1, 5'd8, 5'd8, 5'd0, 0,1, 6'b110010, 2'd1};
        vecs[9] = '{0,0,0, 5'd8, 5'd8, 5'd8, 1,0, 6'b000000, 2'd0};

        idle();
        reset = 1;
        mem_busy = 1; branch_taken = 1;
        #3;
        chk("rst_state", 32'(state), 0);
        chk("rst_ctl", 32'(ctl), 0);
        chk("rst_stall", 32'(stall_cycles), 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        idle();
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 10; i++) begin
            mem_busy = vecs[i].mb; branch_taken = vecs[i].br; ex_mem_read = vecs[i].rd;
            ex_rt = vecs[i].xrt; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rt = vecs[i].urt; jump = vecs[i].jmp;
            #1;
            chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
            tick();
            chk($sformatf("vec%0d_nstate", i), 32'(state), 32'(vecs[i].exp_nst));
            idle();
            tick();
            chk($sformatf("vec%0d_back_run", i), 32'(state), 0);
        end

        // Load-use: one-cycle stall, detection suppressed in LOAD_STALL.
        stat_clr = 1; tick(); stat_clr = 0;
        chk("lu_stat_clr", 32'(stall_cycles), 0);
        load_use8();
        #1 chk("lu_ctl", 32'(ctl), 32'b110010);
        tick();
        chk("lu_state", 32'(state), 1);
        chk("lu_stall1", 32'(stall_cycles), 1);
        #1 chk("lu_suppressed_ctl", 32'(ctl), 0);
        tick();
        chk("lu_back_run", 32'(state), 0);
        chk("lu_stall_after", 32'(stall_cycles), 1);
        idle(); tick();

        // Branch taken while in LOAD_STALL.
        load_use8(); tick();
        branch_taken = 1;
        #1 chk("ls_branch_ctl", 32'(ctl), 32'b001010);
        tick();
        chk("ls_branch_state", 32'(state), 0);
        idle(); tick();

        // mem_busy while in LOAD_STALL.
        load_use8(); tick();
        mem_busy = 1;
        #1 chk("ls_mb_ctl", 32'(ctl), 32'b110101);
        tick();
        chk("ls_mb_state", 32'(state), 2);
        idle();
        #1 chk("mw_release_ctl", 32'(ctl), 0);
        tick();
        chk("mw_release_state", 32'(state), 0);

        // Three busy cycles: no timeout.
        stat_clr = 1; tick(); stat_clr = 0;
        mem_busy = 1;
        repeat (3) tick();
        chk("mw3_state", 32'(state), 2);
        chk("mw3_ctl", 32'(ctl), 32'b110101);
        chk("mw3_timeout", 32'(mem_timeout), 0);
        chk("mw3_stall", 32'(stall_cycles), 3);
        mem_busy = 0;
        #1 chk("mw3_drop_ctl", 32'(ctl), 0);
        tick();
        chk("mw3_run", 32'(state), 0);
        chk("mw3_stall_hold", 32'(stall_cycles), 3);

        // Six busy cycles: timeout after the 4th edge, sticky; stall saturates.
        stat_clr = 1; tick(); stat_clr = 0;
        mem_busy = 1;
        repeat (3) tick();
        chk("to_edge3", 32'(mem_timeout), 0);
        tick();
        chk("to_edge4", 32'(mem_timeout), 1);
        repeat (2) tick();
        chk("stall_sat", 32'(stall_cycles), 3);
        mem_busy = 0;
        tick();
        chk("to_sticky1", 32'(mem_timeout), 1);
        tick();
        chk("to_sticky2", 32'(mem_timeout), 1);

        // stat_clr beats increment.
        mem_busy = 1; stat_clr = 1;
        #1 chk("clr_pc_hold", 32'(pc_hold), 1);
        tick();
        chk("clr_prio", 32'(stall_cycles), 0);
        stat_clr = 0;
        tick();
        chk("clr_then_inc", 32'(stall_cycles), 1);
        chk("pre_rst_state", 32'(state), 2);

        // Async reset between edges in MEM_WAIT.
        #2 reset = 1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_ctl", 32'(ctl), 0);
        chk("arst_stall", 32'(stall_cycles), 0);
        chk("arst_timeout", 32'(mem_timeout), 0);
        @(negedge clk);
        reset = 0;
        repeat (3) tick();
        chk("arst_wait_cleared", 32'(mem_timeout), 0);
        tick();
        chk("arst_wait_refill", 32'(mem_timeout), 1);
        idle(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
